// File: rtl/display_cronometro.sv
// Stopwatch display driver: converts binary seconds plus BCD tenths into active-low
// seven-segment patterns, decodes the stopwatch state into indicator flags and blinks the display while paused.
module display_cronometro #(
    parameter int BIN_W     = 10,
    parameter int N_DIG     = 3,
    parameter int BLINK_DIV = 5000000,
    parameter int LZB       = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   seg,
    input  logic [3:0]         dec,
    input  logic               enable,
    input  logic [2:0]         estado_atual,
    output logic [7*N_DIG-1:0] digitos,
    output logic [6:0]         decimos,
    output logic               reset,
    output logic               conta,
    output logic               pausa,
    output logic               para,
    output logic               busy
);

    localparam int BCD_W  = 4 * N_DIG;
    localparam int CNT_W  = $clog2(BLINK_DIV + 1);
    localparam int STEP_W = $clog2(BIN_W + 1);
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(N_DIG);

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t             state;
    logic [BIN_W-1:0]   seg_lat;
    logic [BIN_W-1:0]   seg_sh;
    logic [3:0]         dec_lat;
    logic [BCD_W-1:0]   bcd;
    logic [STEP_W-1:0]  step;
    logic               upd;
    logic [7*N_DIG-1:0] disp_dig;
    logic [6:0]         disp_dec;
    logic [CNT_W-1:0]   blink_cnt;
    logic               phase;

    logic [BCD_W-1:0]   dabbled;
    logic [7*N_DIG-1:0] dig_comb;
    logic [6:0]         dec_comb;
    logic               ovf;
    logic               leading;

    always_comb begin
        dabbled = bcd;
        for (int k = 0; k < N_DIG; k++)
            if (dabbled[4*k +: 4] >= 4'd5) dabbled[4*k +: 4] = dabbled[4*k +: 4] + 4'd3;
    end

    assign ovf = ({{(64-BIN_W){1'b0}}, seg_lat} >= LIMIT);

    // NOTE: blocking assignments are correct here; 'leading' must carry from one digit to the next within the same pass.
    always_comb begin
        dig_comb = '0;
        leading  = 1'b1;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            if (ovf) begin
                dig_comb[7*k +: 7] = GLYPH_DASH;
            end else if (LZB != 0 && leading && k != 0 && bcd[4*k +: 4] == 4'd0) begin
                dig_comb[7*k +: 7] = GLYPH_BLANK;
            end else begin
                dig_comb[7*k +: 7] = glyph(bcd[4*k +: 4]);
                leading = 1'b0;
            end
        end
        dec_comb = (dec_lat > 4'd9) ? GLYPH_BLANK : glyph(dec_lat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            upd     <= 1'b0;
            step    <= '0;
            bcd     <= '0;
            seg_lat <= '0;
            seg_sh  <= '0;
            dec_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    upd <= 1'b0;
                    if (enable) begin
                        seg_lat <= seg;
                        seg_sh  <= seg;
                        dec_lat <= dec;
                        bcd     <= '0;
                        step    <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= {dabbled[BCD_W-2:0], seg_sh[BIN_W-1]};
                    seg_sh <= seg_sh << 1;
                    step   <= step + 1'b1;
                    if (step == STEP_W'(BIN_W - 1)) state <= LOAD;
                end
                LOAD: begin
                    // Patterns are taken from the finished BCD on the following edge.
                    upd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_dig  <= {N_DIG{GLYPH_0}};
            disp_dec  <= GLYPH_0;
            reset     <= 1'b1;
            conta     <= 1'b0;
            pausa     <= 1'b0;
            para      <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            reset <= (estado_atual == 3'd0);
            conta <= (estado_atual == 3'd1);
            pausa <= (estado_atual == 3'd2);
            para  <= (estado_atual == 3'd3);
            if (upd) begin
                disp_dig <= dig_comb;
                disp_dec <= dec_comb;
            end
            // Leaving the pause state clears the blink on the same edge pausa drops.
            if (!pausa || estado_atual != 3'd2) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt >= CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign digitos = phase ? {N_DIG{GLYPH_BLANK}} : disp_dig;
    assign decimos = phase ? GLYPH_BLANK : disp_dec;

endmodule

// File: tb/tb_display_cronometro.sv
// Directed bench for display_cronometro: two instances (defaults, and LZB=1 with a short blink)
// share the stimulus; expected patterns are queued at capture and compared when the display updates.
module tb_display_cronometro;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  seg;
    logic [3:0]  dec;
    logic        enable;
    logic [2:0]  estado_atual;
    logic [20:0] dig_a, dig_b;
    logic [6:0]  dcm_a, dcm_b;
    logic        rs_a, co_a, pa_a, pr_a, busy_a;
    logic        rs_b, co_b, pa_b, pr_b, busy_b;

    always #5 clk = ~clk;

    display_cronometro dut_a (
        .clk(clk), .rst(rst), .seg(seg), .dec(dec), .enable(enable), .estado_atual(estado_atual),
        .digitos(dig_a), .decimos(dcm_a), .reset(rs_a), .conta(co_a), .pausa(pa_a), .para(pr_a),
        .busy(busy_a)
    );

    display_cronometro #(.LZB(1), .BLINK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .seg(seg), .dec(dec), .enable(enable), .estado_atual(estado_atual),
        .digitos(dig_b), .decimos(dcm_b), .reset(rs_b), .conta(co_b), .pausa(pa_b), .para(pr_b),
        .busy(busy_b)
    );

    typedef struct {
        logic [20:0] dig_a;
        logic [20:0] dig_b;
        logic [6:0]  dcm;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [20:0] cur_a, cur_b;
    logic [6:0]  cur_dcm;

    localparam logic [20:0] ZEROS  = {3{7'b0000001}};
    localparam logic [20:0] BLANKS = {3{7'b1111111}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] gm(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;  default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] exp_dig(input int s, input bit lzb);
        logic [20:0] r;
        int p;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            p = (k == 0) ? 1 : (k == 1) ? 10 : 100;
            if (s >= 1000)                   r[7*k +: 7] = 7'b1111110;
            else if (lzb && k > 0 && s < p)  r[7*k +: 7] = 7'b1111111;
            else                             r[7*k +: 7] = gm((s / p) % 10);
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_dcm(input int d);
        return (d > 9) ? 7'b1111111 : gm(d);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_dig_a"}, 64'(dig_a), 64'(ZEROS));
        check({tag, "_dig_b"}, 64'(dig_b), 64'(ZEROS));
        check({tag, "_dcm"},   64'({dcm_a, dcm_b}), 64'({2{7'b0000001}}));
        check({tag, "_ind"},   64'({rs_a, co_a, pa_a, pr_a, rs_b, co_b, pa_b, pr_b}), 64'(8'b1000_1000));
        check({tag, "_busy"},  64'({busy_a, busy_b}), 64'(0));
    endtask

    // Capture edge is edge 0; the second enable (if any) is presented at edge 'inject'.
    task automatic capture(input string tag, input int s, input int d, input int inject);
        exp_t e;
        int   busy_cnt;
        @(negedge clk);
        seg = 10'(s);
        dec = 4'(d);
        enable = 1'b1;
        sb.push_back('{exp_dig(s, 1'b0), exp_dig(s, 1'b1), exp_dcm(d)});
        busy_cnt = 0;
        for (int ed = 0; ed <= 11; ed++) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            if (busy_a) busy_cnt++;
            if (inject != 0 && ed == inject - 1) begin
                seg = 10'd5;
                dec = 4'd1;
                enable = 1'b1;
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(11));
        check({tag, "_hold_a"}, 64'(dig_a), 64'(cur_a));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_dig_a"}, 64'(dig_a), 64'(e.dig_a));
        check({tag, "_dig_b"}, 64'(dig_b), 64'(e.dig_b));
        check({tag, "_dcm"},   64'({dcm_a, dcm_b}), 64'({e.dcm, e.dcm}));
        cur_a = e.dig_a;
        cur_b = e.dig_b;
        cur_dcm = e.dcm;
    endtask

    initial begin
        rst = 1'b1; seg = '0; dec = '0; enable = 1'b0; estado_atual = 3'd1;
        cur_a = ZEROS; cur_b = ZEROS; cur_dcm = 7'b0000001;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        capture("default_987", 987, 5, 0);
        check("default_987_literal", 64'(dig_a), 64'(21'b0000100_0000000_0001111));
        capture("busy_ignore", 321, 4, 4);
        repeat (14) @(posedge clk);
        #1;
        check("busy_ignore_later", 64'(dig_a), 64'(cur_a));
        capture("overflow", 1000, 3, 0);
        check("overflow_literal", 64'({dig_a, dcm_a}), 64'({21'b1111110_1111110_1111110, 7'b0000110}));
        capture("dec_blank", 40, 12, 0);
        capture("lzb_7", 7, 9, 0);
        check("lzb_7_literal", 64'(dig_b), 64'(21'b1111111_1111111_0001111));
        capture("lzb_0", 0, 0, 0);
        capture("lzb_205", 205, 7, 0);

        for (int st = 0; st < 8; st++) begin
            @(negedge clk);
            estado_atual = 3'(st);
            @(posedge clk);
            #1;
            check($sformatf("ind_state%0d", st), 64'({rs_a, co_a, pa_a, pr_a, rs_b, co_b, pa_b, pr_b}),
                  64'({2{(st == 0), (st == 1), (st == 2), (st == 3)}}));
        end
        @(negedge clk);
        estado_atual = 3'd1;

        @(negedge clk);
        estado_atual = 3'd2;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (((i / 4) % 2) == 1)
                check($sformatf("blink_%0d", i), 64'({dig_b, dcm_b}), 64'({BLANKS, 7'b1111111}));
            else
                check($sformatf("blink_%0d", i), 64'({dig_b, dcm_b}), 64'({cur_b, cur_dcm}));
        end
        check("blink_pausa", 64'(pa_b), 64'(1));
        // Stop on a blank phase so the return to visible is observable.
        repeat (4) @(posedge clk);
        #1;
        check("blink_blank_again", 64'(dig_b), 64'(BLANKS));
        @(negedge clk);
        estado_atual = 3'd1;
        @(posedge clk);
        #1;
        check("resume_visible", 64'({dig_b, dcm_b, co_b, pa_b}), 64'({cur_b, cur_dcm, 1'b1, 1'b0}));
        check("resume_a_visible", 64'(dig_a), 64'(cur_a));

        @(negedge clk);
        estado_atual = 3'd0;
        seg = 10'd555;
        dec = 4'd6;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("abort");
        repeat (15) @(posedge clk);
        #1;
        check_reset_state("abort_later");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_cronometro.md
DISPLAY_CRONOMETRO -- requirements
Module: display_cronometro

Interface
REQ-001 SHALL have parameter BIN_W, default 10: width of the seconds input.
REQ-002 SHALL have parameter N_DIG, default 3: number of integer display digits.
REQ-003 SHALL have parameter BLINK_DIV, default 5000000: clock cycles per blink half-period, minimum 1.
REQ-004 SHALL have parameter LZB, default 0: 1 enables leading-zero blanking.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port seg, input, BIN_W bits: elapsed seconds, unsigned binary.
REQ-008 SHALL have port dec, input, 4 bits: tenths of a second, BCD.
REQ-009 SHALL have port enable, input, 1 bit: capture request for seg and dec.
REQ-010 SHALL have port estado_atual, input, 3 bits: stopwatch FSM state.
REQ-011 SHALL have port digitos, output, 7*N_DIG bits: segment patterns; digit k at bits [7k+6:7k], k=0 is units; per digit bit 6=a … bit 0=g; active-low.
REQ-012 SHALL have port decimos, output, 7 bits: tenths digit pattern, same encoding as digitos.
REQ-013 SHALL have ports reset, conta, pausa, para, output, 1 bit each: registered state indicators.
REQ-014 SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-015 SHALL use the glyph table 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111, dash=1111110.
REQ-016 SHALL implement an FSM with states IDLE, CONV, LOAD.
REQ-017 SHALL, in IDLE with enable=1, latch seg and dec, clear the BCD scratch (4*N_DIG bits), set busy=1, and go to CONV.
REQ-018 SHALL perform one double-dabble step per cycle in CONV: add 3 to each nibble ≥5, then shift left by one bit, taking the next seg bit MSB-first; CONV lasts exactly BIN_W cycles.
REQ-019 SHALL, in LOAD, update digitos and decimos, clear busy, and return to IDLE; outputs change exactly BIN_W+2 clock edges after the capture edge.
REQ-020 SHALL ignore enable while busy=1; no queuing.
REQ-021 SHALL, when the latched seg ≥ 10^N_DIG, show dash on every integer digit; decimos is still decoded normally.
REQ-022 SHALL, when latched dec > 9, show blank on decimos.
REQ-023 SHALL, when LZB=1, show blank on each zero digit above the most significant nonzero digit; the units digit is never blanked.
REQ-024 SHALL decode estado_atual into the indicators each cycle, registered: 0 gives reset=1, 1 gives conta=1, 2 gives pausa=1, 3 gives para=1, all others 0; states 4–7 give all indicators 0.
REQ-025 SHALL, while the registered pausa=1, toggle a blink phase every BLINK_DIV cycles; in the blank phase digitos and decimos read all-blank, and the stored patterns are unchanged.
REQ-026 SHALL, when pausa deasserts, clear the blink counter and phase on the next edge, so display is immediately visible.
REQ-027 SHALL clamp the blink counter at BLINK_DIV-1 before wrap to 0; no overflow.

Reset
REQ-028 SHALL, on an edge with rst=1, set the FSM to IDLE, busy=0, every digitos digit to "0", decimos to "0", reset=1, conta=pausa=para=0, and blink counter and phase to 0.
REQ-029 SHALL give rst priority over enable and abort any in-flight conversion without updating the outputs.

Verification
REQ-030 SHALL verify defaults: seg=987, dec=5, 1-cycle enable gives, 12 edges later, digitos=0000100_0000000_0001111 and decimos=0100100, with busy high for 11 cycles.
REQ-031 SHALL verify overflow: seg=1000, dec=3 gives all three digits 1111110 and decimos=0000110.
REQ-032 SHALL verify blanking with LZB=1: seg=7 gives 1111111_1111111_0001111; seg=0 gives units 0000001.
REQ-033 SHALL verify busy handling: a second enable with seg=5 pulsed 4 cycles after the first is ignored, and the display shows the first value.
REQ-034 SHALL verify blink with BLINK_DIV=4, estado_atual=2: display visible 4 cycles, blank 4 cycles, repeating; estado_atual=1 gives visible the next cycle with conta=1.
REQ-035 SHALL verify abort: rst asserted during CONV (cycle 5) gives the REQ-028 values and no later spurious update.
